// File: rtl/scope_pkg.sv
// Shared types and helpers for the multi-channel waveform capture scope.
package scope_pkg;

  typedef enum logic [2:0] {
    S_ROLL  = 3'd0,
    S_ARMED = 3'd1,
    S_WAIT  = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4
  } scope_state_e;

  localparam logic [1:0] ZOOM_X1     = 2'd0;
  localparam logic [1:0] ZOOM_X2     = 2'd1;
  localparam logic [1:0] ZOOM_X4     = 2'd2;
  localparam logic [1:0] ZOOM_X1_ALT = 2'd3;

  localparam int unsigned ZMAX_W = 16;

  // Gain about mid-scale, clamped to [0, 2**w - 1] instead of wrapping.
  function automatic logic [ZMAX_W-1:0] saturate_zoom(input logic [ZMAX_W-1:0] s,
                                                      input logic [1:0] zoom,
                                                      input int unsigned w);
    int mid;
    int top;
    int g;
    int z;
    mid = 1 << (w - 1);
    top = (1 << w) - 1;
    case (zoom)
      ZOOM_X1, ZOOM_X1_ALT: g = 1;
      ZOOM_X2:              g = 2;
      ZOOM_X4:              g = 4;
      default:              g = 1;
    endcase
    z = mid + g * (int'(s) - mid);
    if (z < 0) return '0;
    if (z > top) return ZMAX_W'(top);
    return ZMAX_W'(z);
  endfunction

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port sample store; registered read returns old data on a same-address write.
module scope_ram #(
  parameter int unsigned DEPTH = 1280,
  parameter int unsigned WIDTH = 20,
  parameter int unsigned AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/waveform_capture_scope.sv
// Multi-channel capture scope: zoomed ring-buffer capture with roll / triggered modes,
// drawn as coloured bands through a 3-stage pixel pipeline.
module waveform_capture_scope
  import scope_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned DEPTH    = 1280,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PRETRIG  = 640,
  parameter int unsigned MARGIN   = 3
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         sample_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] wave_sample,
  input  logic                         freeze,
  input  logic [1:0]                   zoom,
  input  logic                         trig_en,
  input  logic [1:0]                   trig_ch,
  input  logic [SAMPLE_W-1:0]          trig_level,
  input  logic                         rearm,
  input  logic                         off,
  input  logic [CHANNELS*12-1:0]       waveform,
  input  logic [11:0]                  VGA_HORZ_COORD,
  input  logic [11:0]                  VGA_VERT_COORD,
  output logic [3:0]                   VGA_Red_waveform,
  output logic [3:0]                   VGA_Green_waveform,
  output logic [3:0]                   VGA_Blue_waveform,
  output logic [CHANNELS-1:0]          hit,
  output logic [2:0]                   scope_state
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned DW       = CHANNELS * SAMPLE_W;
  localparam int unsigned POST_LEN = DEPTH - PRETRIG;
  localparam int unsigned CH_MASK  = (1 << $clog2(CHANNELS)) - 1;

  scope_state_e        state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       start;
  logic [CW-1:0]       cnt;
  logic [SAMPLE_W-1:0] prev [CHANNELS];

  logic [DW-1:0]       wdata_c;
  logic [SAMPLE_W-1:0] cur_c;
  logic [SAMPLE_W-1:0] prev_sel_c;
  logic                we_c;
  logic                trig_c;
  logic [AW-1:0]       trig_start_c;
  logic [AW-1:0]       rd_addr_c;

  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_data;
  logic [11:0]         x1, v1, x2, v2;
  logic [CHANNELS-1:0] hit_c;
  logic [11:0]         col_c;

  assign scope_state = state;

  // Zoom every channel and pick out the trigger channel's new and previous sample.
  always_comb begin
    logic [SAMPLE_W-1:0] z;
    z          = '0;
    wdata_c    = '0;
    cur_c      = '0;
    prev_sel_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      z = SAMPLE_W'(saturate_zoom(ZMAX_W'(wave_sample[c*SAMPLE_W +: SAMPLE_W]), zoom, SAMPLE_W));
      wdata_c[c*SAMPLE_W +: SAMPLE_W] = z;
      if ((int'(trig_ch) & int'(CH_MASK)) == c) begin
        cur_c      = z;
        prev_sel_c = prev[c];
      end
    end
  end

  assign we_c   = ~RESET & sample_valid & ~freeze & ((state != S_HOLD) | rearm);
  assign trig_c = (prev_sel_c <= trig_level) & (trig_level < cur_c);
  assign trig_start_c = (int'(wr_ptr) >= int'(PRETRIG)) ? AW'(int'(wr_ptr) - int'(PRETRIG))
                                                        : AW'(int'(wr_ptr) + int'(POST_LEN));

  // Capture FSM; freeze holds every piece of state, mode changes included.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= trig_en ? S_ARMED : S_ROLL;
      wr_ptr <= '0;
      start  <= '0;
      cnt    <= '0;
      for (int c = 0; c < CHANNELS; c++) prev[c] <= '0;
    end else if (!freeze) begin
      if (we_c) begin
        wr_ptr <= (int'(wr_ptr) == int'(DEPTH) - 1) ? '0 : wr_ptr + AW'(1);
        for (int c = 0; c < CHANNELS; c++) prev[c] <= wdata_c[c*SAMPLE_W +: SAMPLE_W];
      end
      if (!trig_en) begin
        state <= S_ROLL;
        start <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          S_ROLL: begin
            state <= S_ARMED;
            cnt   <= '0;
          end
          S_ARMED: if (we_c) begin
            cnt <= cnt + CW'(1);
            if (int'(cnt) + 1 >= int'(PRETRIG)) state <= S_WAIT;
          end
          S_WAIT: if (we_c && trig_c) begin
            start <= trig_start_c;
            cnt   <= CW'(1);
            state <= (POST_LEN == 1) ? S_HOLD : S_POST;
          end
          S_POST: if (we_c) begin
            cnt <= cnt + CW'(1);
            if (int'(cnt) + 1 >= int'(POST_LEN)) state <= S_HOLD;
          end
          S_HOLD: if (rearm) begin
            state <= S_ARMED;
            cnt   <= we_c ? CW'(1) : '0;
          end
          default: state <= S_ROLL;
        endcase
      end
    end
  end

  // Stage 1 address: display start plus x, wrapped into the ring.
  always_comb begin
    int sum;
    sum       = int'(start) + int'(VGA_HORZ_COORD);
    rd_addr_c = '0;
    if (int'(VGA_HORZ_COORD) < int'(DEPTH))
      rd_addr_c = (sum >= int'(DEPTH)) ? AW'(sum - int'(DEPTH)) : AW'(sum);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      x1      <= '0;
      v1      <= '0;
      rd_addr <= '0;
      x2      <= '0;
      v2      <= '0;
    end else begin
      x1      <= VGA_HORZ_COORD;
      v1      <= VGA_VERT_COORD;
      rd_addr <= rd_addr_c;
      x2      <= x1;
      v2      <= v1;
    end
  end

  scope_ram #(.DEPTH(DEPTH), .WIDTH(DW), .AW(AW)) u_ram (
    .clk   (CLOCK),
    .we    (we_c),
    .waddr (wr_ptr),
    .wdata (wdata_c),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Band test in signed int space so sample 0 and full scale cannot wrap; lowest channel wins.
  always_comb begin
    int y;
    y     = 0;
    hit_c = '0;
    col_c = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      y = (1 << SAMPLE_W) - int'(rd_data[c*SAMPLE_W +: SAMPLE_W]);
      hit_c[c] = (int'(x2) < int'(DEPTH)) && (int'(v2) > y - int'(MARGIN)) &&
                 (int'(v2) < y + int'(MARGIN));
      if (hit_c[c]) col_c = waveform[c*12 +: 12];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hit                <= '0;
      VGA_Red_waveform   <= '0;
      VGA_Green_waveform <= '0;
      VGA_Blue_waveform  <= '0;
    end else begin
      hit                <= hit_c;
      VGA_Red_waveform   <= off ? 4'd0 : col_c[11:8];
      VGA_Green_waveform <= off ? 4'd0 : col_c[7:4];
      VGA_Blue_waveform  <= off ? 4'd0 : col_c[3:0];
    end
  end

endmodule

// File: tb/tb_waveform_capture_scope.sv
// Directed-sequence bench with random sample data, checked against a sample-level reference model.
module tb_waveform_capture_scope;
  import scope_pkg::*;

  localparam int SW = 10;
  localparam int D  = 1280;
  localparam int CH = 2;
  localparam int PT = 640;
  localparam int MG = 3;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          sample_valid;
  logic [CH*SW-1:0] wave_sample;
  logic          freeze;
  logic [1:0]    zoom;
  logic          trig_en;
  logic [1:0]    trig_ch;
  logic [SW-1:0] trig_level;
  logic          rearm;
  logic          off;
  logic [CH*12-1:0] waveform;
  logic [11:0]   hx, vy;
  logic [3:0]    red, green, blue;
  logic [CH-1:0] hit;
  logic [2:0]    scope_state;

  always #5 CLOCK = ~CLOCK;

  waveform_capture_scope #(
    .SAMPLE_W(SW), .DEPTH(D), .CHANNELS(CH), .PRETRIG(PT), .MARGIN(MG)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .sample_valid(sample_valid), .wave_sample(wave_sample),
    .freeze(freeze), .zoom(zoom), .trig_en(trig_en), .trig_ch(trig_ch),
    .trig_level(trig_level), .rearm(rearm), .off(off), .waveform(waveform),
    .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .VGA_Red_waveform(red), .VGA_Green_waveform(green), .VGA_Blue_waveform(blue),
    .hit(hit), .scope_state(scope_state)
  );

  int mem_m [CH][D];
  int prev_m [CH];
  int wp, cnt, start_m;
  scope_state_e st;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int zoom_ref(input int s, input logic [1:0] zm);
    int g = (zm == 2'd1) ? 2 : (zm == 2'd2) ? 4 : 1;
    int r = 512 + g * (s - 512);
    return (r < 0) ? 0 : (r > 1023) ? 1023 : r;
  endfunction

  // One strobe; the model decides what a strobe means at sample granularity.
  task automatic strobe(input int s0, input int s1, input bit rq);
    int z [CH];
    bit wr, trg;
    int ts;
    @(negedge CLOCK);
    wave_sample  = {10'(s1), 10'(s0)};
    sample_valid = 1'b1;
    rearm        = rq;
    @(negedge CLOCK);
    sample_valid = 1'b0;
    rearm        = 1'b0;
    z[0] = zoom_ref(s0, zoom);
    z[1] = zoom_ref(s1, zoom);
    wr  = !freeze && (st != S_HOLD || rq);
    trg = wr && st == S_WAIT && prev_m[0] <= int'(trig_level) && int'(trig_level) < z[0];
    ts  = (wp - PT + D) % D;
    if (wr) begin
      for (int c = 0; c < CH; c++) begin
        mem_m[c][wp] = z[c];
        prev_m[c]    = z[c];
      end
      wp = (wp + 1) % D;
    end
    if (!freeze) begin
      case (st)
        S_ARMED: if (wr) begin cnt++; if (cnt >= PT) st = S_WAIT; end
        S_WAIT:  if (trg) begin st = S_POST; start_m = ts; cnt = 1; end
        S_POST:  if (wr) begin cnt++; if (cnt >= D - PT) st = S_HOLD; end
        S_HOLD:  if (rq) begin st = S_ARMED; cnt = wr ? 1 : 0; end
        default: ;
      endcase
    end
    chk("state", 32'(scope_state), 32'(st));
  endtask

  task automatic set_trig(input bit en);
    @(negedge CLOCK);
    trig_en = en;
    @(negedge CLOCK);
    if (!en) begin st = S_ROLL; start_m = 0; cnt = 0; end
    else if (st == S_ROLL) begin st = S_ARMED; cnt = 0; end
    chk("mode_state", 32'(scope_state), 32'(st));
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    st = trig_en ? S_ARMED : S_ROLL;
    wp = 0; cnt = 0; start_m = 0;
    for (int c = 0; c < CH; c++) prev_m[c] = 0;
    chk("rst_state", 32'(scope_state), 32'(st));
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    RESET = 1'b0;
  endtask

  // Pixel at (x,v): coordinates in, outputs three clock edges later.
  task automatic probe(input int x, input int v, input string tag);
    int a, y, eh, ergb;
    @(negedge CLOCK);
    hx = 12'(x);
    vy = 12'(v);
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    eh = 0;
    ergb = 0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (x < D) begin
        a = (start_m + x) % D;
        y = 1024 - mem_m[c][a];
        if (v > y - MG && v < y + MG) begin
          eh |= (1 << c);
          ergb = int'((waveform >> (12 * c)) & 24'hFFF);
        end
      end
    end
    if (off) ergb = 0;
    chk({tag, ".hit"}, 32'(hit), 32'(eh));
    chk({tag, ".rgb"}, 32'({red, green, blue}), 32'(ergb));
  endtask

  task automatic rand_probes(input int n);
    int x, v, c;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, D - 1));
      c = int'($urandom_range(0, CH - 1));
      v = 1024 - mem_m[c][(start_m + x) % D] + int'($urandom_range(0, 6)) - 3;
      if (v < 0) v = 0;
      probe(x, v, "rnd");
    end
  endtask

  task automatic run_until(input scope_state_e target, input int full);
    int guard = 0;
    while (st != target && guard < 5000) begin
      strobe(full ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 400)),
             int'($urandom_range(0, 1023)), 1'b0);
      guard++;
    end
    chk("reach_target", 32'(scope_state), 32'(target));
  endtask

  initial begin
    int a;
    RESET = 1'b1; sample_valid = 1'b0; wave_sample = '0; freeze = 1'b0; zoom = 2'd0;
    trig_en = 1'b0; trig_ch = 2'd0; trig_level = 10'd512; rearm = 1'b0; off = 1'b0;
    waveform = {12'hA5C, 12'h3F1}; hx = '0; vy = '0;
    repeat (2) @(negedge CLOCK);
    do_reset();

    // zoom saturation and band edges
    zoom = 2'd2;
    strobe(1000, 10, 1'b0);
    a = (wp + D - 1) % D;
    probe(a, 1, "zx4_hi");
    probe(a, 4, "zx4_hi_out");
    probe(a, 1026, "zx4_lo_edge");
    probe(a, 1027, "zx4_lo_out");
    probe(a, 0, "zero_nowrap");
    zoom = 2'd1;
    strobe(600, 600, 1'b0);
    a = (wp + D - 1) % D;
    probe(a, 336, "zx2_prio");
    zoom = 2'd0;

    // roll fill and random reads
    for (int i = 0; i < D; i++)
      strobe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    rand_probes(16);
    probe(D, 500, "x_oob");
    probe(4095, 10, "x_max");
    off = 1'b1;
    rand_probes(3);
    off = 1'b0;

    // freeze drops samples and holds state
    freeze = 1'b1;
    for (int i = 0; i < 50; i++) strobe(int'($urandom_range(0, 1023)), 7, 1'b0);
    freeze = 1'b0;
    strobe(123, 456, 1'b0);
    probe((wp + D - 1) % D, 1024 - 123, "post_freeze");
    rand_probes(4);

    // triggered capture: crossing on the last armed sample is ignored
    trig_level = 10'd512;
    set_trig(1'b1);
    for (int i = 0; i < PT - 1; i++) strobe(int'($urandom_range(0, 400)), int'($urandom_range(0, 1023)), 1'b0);
    strobe(700, 50, 1'b0);
    for (int i = 0; i < 259; i++) strobe(int'($urandom_range(0, 400)), int'($urandom_range(0, 1023)), 1'b0);
    strobe(800, 20, 1'b0);
    run_until(S_HOLD, 1);
    for (int i = 0; i < 3; i++) strobe(int'($urandom_range(0, 1023)), 9, 1'b0);
    probe(PT, 1024 - 800, "trig_at_pretrig");
    rand_probes(8);

    // rearm and a second capture
    strobe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
    run_until(S_HOLD, 1);
    rand_probes(8);

    // reset during POST
    strobe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
    run_until(S_POST, 1);
    for (int i = 0; i < 10; i++) strobe(int'($urandom_range(0, 1023)), 3, 1'b0);
    do_reset();
    rand_probes(6);

    // trig_en falling in POST discards the capture
    run_until(S_POST, 1);
    set_trig(1'b0);
    rand_probes(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
